ifid_pipe_reg: RTL and testbench
================================

// Module: ifid_pipe_reg
// PURPOSE
// - IF->ID pipeline register with a 2-entry skid buffer (main M, skid S) and valid/ready handshake.
// - Splits the held instruction into MIPS fields; out_imm16 feeds the immediate sign-extender.
// - Supports flush (branch/jump redirect) and a saturating back-pressure stall counter.
// PARAMETERS
// - PC_W        32             width of the PC carried alongside the instruction
// - NOP_INSTR   32'h0000_0000  instruction value presented when no beat is valid (sll $0,$0,0)
// - CNT_W       16             width of the stall counter
// PORTS
// - clk          in   1      rising-edge clock
// - rst_n        in   1      asynchronous active-low reset
// - in_valid     in   1      IF presents a beat
// - in_ready     out  1      block can accept; registered; equals ~S_valid
// - in_instr     in   32     fetched instruction
// - in_pc        in   PC_W   PC of in_instr
// - flush        in   1      discard all held and incoming beats
// - out_valid    out  1      M holds a valid beat
// - out_ready    in   1      ID/EX consumes the beat
// - out_instr    out  32     instruction in M
// - out_pc       out  PC_W   PC in M
// - out_opcode   out  6      out_instr[31:26]
// - out_rs       out  5      out_instr[25:21]
// - out_rt       out  5      out_instr[20:16]
// - out_rd       out  5      out_instr[15:11]
// - out_shamt    out  5      out_instr[10:6]
// - out_funct    out  6      out_instr[5:0]
// - out_imm16    out  16     out_instr[15:0], to the sign-extender
// - out_jidx     out  26     out_instr[25:0], jump index
// - stall_cnt    out  CNT_W  cycles with out_valid & ~out_ready; saturates at all-ones
// BEHAVIOUR
// - Reset (rst_n low, async): M_valid=0, S_valid=0, out_instr=NOP_INSTR, out_pc=0,
//   in_ready=1, stall_cnt=0. All field outputs follow from out_instr.
// - acc = in_valid & in_ready. fire = out_valid & out_ready.
// - Per rising edge, without flush:
//   - S_valid & fire: M<=S, S cleared. No accept is possible because in_ready=0.
//   - ~S_valid & acc & (~M_valid | fire): M<=input.
//   - ~S_valid & acc & M_valid & ~fire: S<=input; M held.
//   - ~acc & fire & ~S_valid: M_valid<=0; out_instr<=NOP_INSTR.
// - Latency 1 cycle from acc to out_valid when the block is empty.
// - Throughput 1 beat/cycle while out_ready stays high.
// - in_ready is driven from the S_valid flop. No combinational path from out_ready to in_ready.
// - M is never overwritten while out_valid & ~out_ready. Beat order is strictly preserved.
// - flush=1 at an edge: M_valid<=0, S_valid<=0, out_instr<=NOP_INSTR. Any input beat that
//   edge is dropped, even if acc=1. flush has priority over fire and acc.
//   in_ready=1 on the next cycle.
// - Field outputs are pure wiring of out_instr. They show NOP fields whenever out_valid=0.
// - stall_cnt increments when out_valid & ~out_ready. It holds at 2^CNT_W-1.
//   It is not cleared by flush, only by reset.
// - Reset asserted mid-transfer clears all state on the same instant, regardless of clk.
// TESTING
// - Reset: hold rst_n=0 -> out_valid=0, in_ready=1, out_instr=0, stall_cnt=0; release ->
//   no change until in_valid.
// - Stream: instr 0x2008_FFFC@pc 0x0, then 0x0109_5020@pc 0x4 back-to-back, out_ready=1 ->
//   out_valid 1 cycle later each; first beat out_imm16=0xFFFC, out_rt=8, out_opcode=0x08.
// - Back-pressure: out_ready=0, push A,B,C -> A in M, B in S, in_ready=0, C held by IF;
//   raise out_ready -> A,B,C appear in order; stall_cnt equals the low-ready cycle count.
// - Flush with S full and in_valid=1 -> next cycle out_valid=0, in_ready=1, out_instr=0;
//   the dropped beat never appears.
// - Simultaneous fire+acc with S empty -> M replaced in one cycle, S stays empty, no bubble.
// - Async reset mid-stream (rst_n low between edges) -> outputs cleared immediately.
// - Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/ifid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifid_pipe_reg
// Purpose  : IF->ID pipeline register. A two-entry skid buffer holds beats:
//            M (main, presented to ID) and S (skid). The valid/ready handshake
//            runs on both sides. The held instruction is split into MIPS fields.
//            A flush discards every held beat and the incoming beat.
//            A saturating counter records back-pressure cycles.
// Ports    : clk, rst_n                  clock, async active-low reset
//            in_valid/in_ready/in_instr/in_pc      upstream (IF) side
//            flush                                 redirect: drop everything
//            out_valid/out_ready/out_instr/out_pc  downstream (ID) side
//            out_opcode..out_jidx                  instruction field taps
//            stall_cnt                             out_valid & ~out_ready cycles
// Revision : 1.0 - initial release
// ============================================================================
module ifid_pipe_reg #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [5:0]       out_opcode,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [5:0]       out_funct,
  output logic [15:0]      out_imm16,
  output logic [25:0]      out_jidx,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_m_valid;
  logic [31:0]      r_m_instr;
  logic [PC_W-1:0]  r_m_pc;
  logic             r_s_valid;
  logic [31:0]      r_s_instr;
  logic [PC_W-1:0]  r_s_pc;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_acc;
  logic w_fire;

  // in_ready comes straight from the S flop, so out_ready never reaches it
  // combinationally; S being empty guarantees room for one more beat.
  assign w_acc  = in_valid & ~r_s_valid;
  assign w_fire = r_m_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_instr <= NOP_INSTR;
      r_m_pc    <= '0;
      r_s_valid <= 1'b0;
      r_s_instr <= NOP_INSTR;
      r_s_pc    <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_instr <= NOP_INSTR;
    end else if (r_s_valid) begin
      // S full: nothing can be accepted; only the M->ID transfer advances.
      if (w_fire) begin
        r_m_instr <= r_s_instr;
        r_m_pc    <= r_s_pc;
        r_s_valid <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_m_valid || w_fire) begin
        // M empty or draining this edge: the new beat goes straight to M.
        r_m_valid <= 1'b1;
        r_m_instr <= in_instr;
        r_m_pc    <= in_pc;
      end else begin
        // M stalled: park the beat in S so M is never overwritten.
        r_s_valid <= 1'b1;
        r_s_instr <= in_instr;
        r_s_pc    <= in_pc;
      end
    end else if (w_fire) begin
      r_m_valid <= 1'b0;
      r_m_instr <= NOP_INSTR;
    end
  end

  // Back-pressure counter: sticks at all-ones and ignores flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_m_valid && !out_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  assign in_ready   = ~r_s_valid;
  assign out_valid  = r_m_valid;
  assign out_instr  = r_m_instr;
  assign out_pc     = r_m_pc;
  assign stall_cnt  = r_stall_cnt;

  assign out_opcode = r_m_instr[31:26];
  assign out_rs     = r_m_instr[25:21];
  assign out_rt     = r_m_instr[20:16];
  assign out_rd     = r_m_instr[15:11];
  assign out_shamt  = r_m_instr[10:6];
  assign out_funct  = r_m_instr[5:0];
  assign out_imm16  = r_m_instr[15:0];
  assign out_jidx   = r_m_instr[25:0];

endmodule
`default_nettype wire

// File: tb/tb_ifid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifid_pipe_reg
// Purpose  : Self-checking bench for ifid_pipe_reg. A queue of held beats
//            serves as the reference (front = M, size 2 = S full). A second
//            instance with a 4-bit counter shares the stimulus so saturation
//            is easy to reach.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifid_pipe_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm16;
  logic [25:0] out_jidx;
  logic [15:0] stall_cnt;

  logic        in_ready4, out_valid4;
  logic [31:0] out_instr4, out_pc4;
  logic [5:0]  out_opcode4, out_funct4;
  logic [4:0]  out_rs4, out_rt4, out_rd4, out_shamt4;
  logic [15:0] out_imm164;
  logic [25:0] out_jidx4;
  logic [3:0]  stall_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  beat_t q[$];
  int    m_stall16 = 0;
  int    m_stall4  = 0;

  always #5 clk = ~clk;

  ifid_pipe_reg #(.PC_W(32), .NOP_INSTR(32'h0), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .out_jidx(out_jidx), .stall_cnt(stall_cnt)
  );

  ifid_pipe_reg #(.PC_W(32), .NOP_INSTR(32'h0), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid4),
    .out_ready(out_ready), .out_instr(out_instr4), .out_pc(out_pc4),
    .out_opcode(out_opcode4), .out_rs(out_rs4), .out_rt(out_rt4), .out_rd(out_rd4),
    .out_shamt(out_shamt4), .out_funct(out_funct4), .out_imm16(out_imm164),
    .out_jidx(out_jidx4), .stall_cnt(stall_cnt4)
  );

  function automatic logic [31:0] exp_instr();
    return (q.size() > 0) ? q[0].instr : 32'h0;
  endfunction

  function automatic logic [31:0] exp_pc();
    return (q.size() > 0) ? q[0].pc : 32'h0;
  endfunction

  // Advance the reference by one rising edge using the inputs as they stand,
  // then let the clock edge happen and settle 1 ns past it.
  task automatic tick();
    beat_t b;
    bit    acc, fire;
    acc  = in_valid && (q.size() < 2);
    fire = (q.size() > 0) && out_ready;
    if (rst_n) begin
      if (q.size() > 0 && !out_ready) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (fire) void'(q.pop_front());
        if (acc) begin
          b.instr = in_instr;
          b.pc    = in_pc;
          q.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    q.delete();
    m_stall16 = 0;
    m_stall4  = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 ||
        out_pc !== 32'h0 || stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_hold: valid=%b ready=%b instr=%h pc=%h cnt=%0d, want 0 1 0 0 0",
               out_valid, in_ready, out_instr, out_pc, stall_cnt);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_ready = i[0];
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b ready=%b instr=%h cnt=%0d, want 0 1 0 0",
               out_valid, in_ready, out_instr, stall_cnt);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h2008_FFFC;
    in_pc     = 32'h0;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'h2008_FFFC || out_imm16 !== 16'hFFFC ||
        out_rt !== 5'd8 || out_opcode !== 6'h08 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL stream_beat0: valid=%b instr=%h imm=%h rt=%0d op=%h pc=%h, want 1 2008fffc fffc 8 08 0",
               out_valid, out_instr, out_imm16, out_rt, out_opcode, out_pc);
    end
    in_instr = 32'h0109_5020;
    in_pc    = 32'h4;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0109_5020 || out_pc !== 32'h4 ||
        out_rs !== 5'd8 || out_rt !== 5'd9 || out_rd !== 5'd10 || out_funct !== 6'h20 ||
        out_shamt !== 5'd0 || out_jidx !== 26'h109_5020 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_beat1: valid=%b instr=%h pc=%h rs=%0d rt=%0d rd=%0d fn=%h rdy=%b, want 1 01095020 4 8 9 10 20 1",
               out_valid, out_instr, out_pc, out_rs, out_rt, out_rd, out_funct, in_ready);
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_opcode !== 6'h0 || out_imm16 !== 16'h0) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%b instr=%h, want 0 0", out_valid, out_instr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c;
    apply_reset();
    a = $urandom; b = $urandom; c = $urandom;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = a; in_pc = 32'h100;
    tick();
    in_instr  = b; in_pc = 32'h104;
    tick();
    in_instr  = c; in_pc = 32'h108;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (out_instr !== a || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: instr=%h ready=%b valid=%b, want %h 0 1", out_instr, in_ready, out_valid, a);
    end
    // A held for 4 edges with ready low.
    n_tests++;
    if (stall_cnt !== 16'd4 || stall_cnt !== m_stall16[15:0]) begin
      n_fail++;
      $display("FAIL bp_stall_cnt: cnt=%0d, want 4", stall_cnt);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_instr !== b || out_pc !== 32'h104 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_b: instr=%h pc=%h ready=%b, want %h 104 1", out_instr, out_pc, in_ready, b);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_instr !== c || out_pc !== 32'h108 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_c: instr=%h pc=%h valid=%b, want %h 108 1", out_instr, out_pc, out_valid, c);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL bp_end: valid=%b cnt=%0d, want 0 4", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h1111_1111; in_pc = 32'h10;
    tick();
    in_instr  = 32'h2222_2222; in_pc = 32'h14;
    tick();
    in_instr  = 32'h3333_3333; in_pc = 32'h18;
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_clear: valid=%b ready=%b instr=%h, want 0 1 0", out_valid, in_ready, out_instr);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_dropped: valid=%b instr=%h, want 0 0", out_valid, out_instr);
    end
    n_tests++;
    if (stall_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL flush_keeps_cnt: cnt=%0d, want 2", stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    apply_reset();
    a = $urandom; b = $urandom;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = a; in_pc = 32'h40;
    tick();
    in_instr  = b; in_pc = 32'h44;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_instr !== b || out_pc !== 32'h44 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_replace: valid=%b instr=%h pc=%h ready=%b, want 1 %h 44 1",
               out_valid, out_instr, out_pc, in_ready, b);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = $urandom;
      in_pc    = 32'h200 + 4 * i;
      tick();
    end
    #2;
    rst_n = 1'b0;
    q.delete();
    m_stall16 = 0;
    m_stall4  = 0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || stall_cnt !== 16'h0 ||
        stall_cnt4 !== 4'h0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b ready=%b instr=%h cnt=%0d, want 0 1 0 0",
               out_valid, in_ready, out_instr, stall_cnt);
    end
    idle_inputs();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hABCD_0123;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_tests++;
    if (stall_cnt4 !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_cnt4: cnt=%0d, want 15", stall_cnt4);
    end
    n_tests++;
    if (stall_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL sat_cnt16: cnt=%0d, want 20", stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] ei;
    int          errs;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_instr  = $urandom;
      in_pc     = $urandom;
      tick();
      ei   = exp_instr();
      errs = 0;
      n_tests++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || out_instr !== ei ||
          (q.size() > 0 && out_pc !== exp_pc())) begin
        errs++;
        $display("FAIL rand_state[%0d]: valid=%b ready=%b instr=%h pc=%h, want %b %b %h %h",
                 i, out_valid, in_ready, out_instr, out_pc, q.size() > 0, q.size() < 2, ei, exp_pc());
      end
      if ({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct} !== ei ||
          out_imm16 !== ei[15:0] || out_jidx !== ei[25:0]) begin
        errs++;
        $display("FAIL rand_fields[%0d]: op=%h rs=%h rt=%h rd=%h sh=%h fn=%h, want instr %h",
                 i, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, ei);
      end
      if (stall_cnt !== m_stall16[15:0] || stall_cnt4 !== m_stall4[3:0]) begin
        errs++;
        $display("FAIL rand_cnt[%0d]: cnt=%0d cnt4=%0d, want %0d %0d",
                 i, stall_cnt, stall_cnt4, m_stall16, m_stall4);
      end
      if (errs != 0) n_fail++;
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
